// File: rtl/bchecc_syndrome_calc_if.sv
// Handshake bundle between the serial codeword source, the syndrome
// calculator and the key-equation solver that consumes the syndromes.
interface bchecc_syndrome_calc_if #(
    parameter int M = 13,
    parameter int T = 15
);
    logic           start_i;
    logic           data_i;
    logic           data_vld_i;
    logic           syn_ack_i;
    logic           busy_o;
    logic [M*T-1:0] syn_o;
    logic           syn_vld_o;
    logic           err_o;

    modport slave (
        input  start_i, data_i, data_vld_i, syn_ack_i,
        output busy_o, syn_o, syn_vld_o, err_o
    );

    modport master (
        output start_i, data_i, data_vld_i, syn_ack_i,
        input  busy_o, syn_o, syn_vld_o, err_o
    );
endinterface

// File: rtl/bchecc_syndrome_calc.sv
// BCH decoder front end: serial Horner evaluation of the odd syndromes
// S1,S3,..,S(2T-1) of a received codeword over GF(2^M).

// One syndrome accumulator: S <= S*alpha^J + din.
module bchecc_syn_lane #(
    parameter int           M         = 13,
    parameter int           J         = 1,
    parameter logic [M-1:0] PRIM_POLY = 13'h001B
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [M-1:0] syn,
    output logic [M-1:0] syn_nxt
);
    // Constant multiply by alpha^J, unrolled as J shift-and-reduce steps.
    function automatic logic [M-1:0] mul_alpha_j(input logic [M-1:0] x);
        logic [M-1:0] r;
        r = x;
        for (int i = 0; i < J; i++)
            r = {r[M-2:0], 1'b0} ^ (r[M-1] ? PRIM_POLY : '0);
        return r;
    endfunction

    assign syn_nxt = mul_alpha_j(syn) ^ {{(M-1){1'b0}}, din};

    // Accumulator: cleared on a new codeword, updated on each accepted bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)    syn <= '0;
        else if (clr) syn <= '0;
        else if (en)  syn <= syn_nxt;
    end
endmodule

module bchecc_syndrome_calc #(
    parameter int           M         = 13,
    parameter int           T         = 15,
    parameter logic [M-1:0] PRIM_POLY = 13'h001B,
    parameter int           CW_LEN    = 4291,
    parameter int           CNT_W     = 13
) (
    input logic                   clk_i,
    input logic                   rst_i,
    bchecc_syndrome_calc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  busy;
    logic                  syn_vld;
    logic                  err;
    logic [T-1:0][M-1:0]   syn;
    logic [T-1:0][M-1:0]   syn_nxt;
    logic                  acc_en;
    logic                  last_bit;

    // start_i outranks data in the same cycle; it clears instead.
    assign acc_en   = (state == ACC) && bus.data_vld_i && !bus.start_i;
    assign last_bit = acc_en && (cnt == CNT_W'(CW_LEN - 1));

    for (genvar j = 0; j < T; j++) begin : g_lane
        bchecc_syn_lane #(
            .M         (M),
            .J         (2*j + 1),
            .PRIM_POLY (PRIM_POLY)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr     (bus.start_i),
            .en      (acc_en),
            .din     (bus.data_i),
            .syn     (syn[j]),
            .syn_nxt (syn_nxt[j])
        );
    end

    // Control FSM with registered busy/valid/error outputs. The error flag is
    // taken from the post-update syndromes so it lines up with syn_vld_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            syn_vld <= 1'b0;
            err     <= 1'b0;
        end else if (bus.start_i) begin
            state   <= ACC;
            cnt     <= '0;
            busy    <= 1'b1;
            syn_vld <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (acc_en) cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        syn_vld <= 1'b1;
                        err     <= |syn_nxt;
                    end
                end
                DONE: begin
                    if (bus.syn_ack_i) begin
                        state   <= IDLE;
                        syn_vld <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o    = busy;
    assign bus.syn_o     = syn;
    assign bus.syn_vld_o = syn_vld;
    assign bus.err_o     = err;
endmodule
